// File: rtl/led_trail_chaser_if.sv
// Pin bundle for the LED trail chaser: the control inputs and the PWM LED drive.
// The master side drives the controls and the slave side (the chaser) drives the LEDs.
`timescale 1ns/1ps

interface led_trail_chaser_if #(
   parameter int NUM_CH = 8
);
   logic [2:0]        speed;
   logic              direction;
   logic [1:0]        mode;
   logic [1:0]        fade_rate;
   logic [NUM_CH-1:0] led_out;

   modport master (
      output speed,
      output direction,
      output mode,
      output fade_rate,
      input  led_out
   );

   modport slave (
      input  speed,
      input  direction,
      input  mode,
      input  fade_rate,
      output led_out
   );
endinterface

// File: rtl/led_trail_chaser.sv
// LED trail chaser: a lit head moves across NUM_CH channels (chase/bounce/pulse/hold)
// and leaves a trail whose brightness halves on every fade tick, rendered through PWM.
//
//  state       | meaning
//  ST_UP       | bounce mode steps the head towards channel NUM_CH-1
//  ST_DOWN     | bounce mode steps the head towards channel 0
`timescale 1ns/1ps

module led_trail_chaser #(
   parameter int NUM_CH       = 8,
   parameter int STEP_W       = 24,
   parameter int FADE_W       = 21,
   parameter int BRIGHT_W     = 5,
   parameter int COMMON_ANODE = 1
) (
   input  logic               clk,
   input  logic               reset,
   led_trail_chaser_if.slave  bus
);

   localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [PW-1:0]       POS_ZERO = '0;
   localparam logic [PW-1:0]       POS_ONE  = PW'(1);
   localparam logic [PW-1:0]       POS_LAST = PW'(NUM_CH - 1);
   localparam logic [BRIGHT_W-1:0] FULL     = '1;

   localparam logic [1:0] M_CHASE  = 2'b00;
   localparam logic [1:0] M_BOUNCE = 2'b01;
   localparam logic [1:0] M_PULSE  = 2'b10;
   localparam logic [1:0] M_HOLD   = 2'b11;

   typedef enum logic {
      ST_UP   = 1'b0,
      ST_DOWN = 1'b1
   } bounce_t;

   logic [2:0]          speed_r;
   logic                direction_r;
   logic [1:0]          mode_r;
   logic [1:0]          fade_rate_r;

   logic [STEP_W-1:0]   step_cnt;
   logic [STEP_W-1:0]   step_thr;
   logic                step_tick;

   logic [FADE_W-1:0]   fade_cnt;
   logic [FADE_W-1:0]   fade_mask;
   logic                fade_tick;

   logic [BRIGHT_W-1:0] pwm_cnt;

   bounce_t             bstate;
   bounce_t             bstate_nxt;
   logic [PW-1:0]       pos;
   logic [PW-1:0]       pos_nxt;
   logic                bounce_up;

   logic                head_load;
   logic                pulse_load;

   logic [BRIGHT_W-1:0] bright [NUM_CH];
   logic [NUM_CH-1:0]   lit;

   // Control pins pass through one register stage before anything uses them.
   always_ff @(posedge clk) begin
      if (reset) begin
         speed_r     <= '0;
         direction_r <= 1'b0;
         mode_r      <= '0;
         fade_rate_r <= '0;
      end else begin
         speed_r     <= bus.speed;
         direction_r <= bus.direction;
         mode_r      <= bus.mode;
         fade_rate_r <= bus.fade_rate;
      end
   end

   // Step timer: a larger speed code lowers the threshold and shortens the period.
   assign step_thr  = {~speed_r, {(STEP_W-3){1'b1}}};
   assign step_tick = (step_cnt >= step_thr);

   always_ff @(posedge clk) begin
      if (reset) begin
         step_cnt <= '0;
      end else if (step_tick) begin
         step_cnt <= '0;
      end else begin
         step_cnt <= step_cnt + STEP_W'(1);
      end
   end

   always_comb begin
      fade_mask = '1;
      case (fade_rate_r)
         2'd0:    fade_mask = {3'b000, {(FADE_W-3){1'b1}}};
         2'd1:    fade_mask = {2'b00,  {(FADE_W-2){1'b1}}};
         2'd2:    fade_mask = {1'b0,   {(FADE_W-1){1'b1}}};
         default: fade_mask = '1;
      endcase
   end

   assign fade_tick = ((fade_cnt & fade_mask) == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         fade_cnt <= '0;
         pwm_cnt  <= '0;
      end else begin
         fade_cnt <= fade_cnt + FADE_W'(1);
         pwm_cnt  <= pwm_cnt + BRIGHT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pos    <= '0;
         bstate <= ST_UP;
      end else begin
         pos    <= pos_nxt;
         bstate <= bstate_nxt;
      end
   end

   // The bounce direction is kept across other modes so re-entering bounce resumes it.
   always_comb begin
      pos_nxt    = pos;
      bstate_nxt = bstate;
      if (step_tick) begin
         case (mode_r)
            M_CHASE: begin
               if (direction_r) begin
                  pos_nxt = (pos == POS_LAST) ? POS_ZERO : pos + POS_ONE;
               end else begin
                  pos_nxt = (pos == POS_ZERO) ? POS_LAST : pos - POS_ONE;
               end
            end
            M_BOUNCE: begin
               if (bstate == ST_UP) begin
                  if (pos == POS_LAST) begin
                     bstate_nxt = ST_DOWN;
                     pos_nxt    = POS_LAST - POS_ONE;
                  end else begin
                     pos_nxt    = pos + POS_ONE;
                  end
               end else begin
                  if (pos == POS_ZERO) begin
                     bstate_nxt = ST_UP;
                     pos_nxt    = POS_ONE;
                  end else begin
                     pos_nxt    = pos - POS_ONE;
                  end
               end
            end
            default: begin
               pos_nxt    = pos;
               bstate_nxt = bstate;
            end
         endcase
      end
   end

   always_comb begin
      head_load  = 1'b0;
      pulse_load = 1'b0;
      case (mode_r)
         M_PULSE: pulse_load = step_tick;
         M_CHASE,
         M_BOUNCE,
         M_HOLD:  head_load  = 1'b1;
         default: head_load  = 1'b0;
      endcase
   end

   assign bounce_up = (bstate == ST_UP);

   // Reloads win over the fade shift; otherwise the level simply holds.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            bright[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (pulse_load || (head_load && (pos == PW'(i)))) begin
               bright[i] <= FULL;
            end else if (fade_tick) begin
               bright[i] <= bright[i] >> 1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lit <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            lit[i] <= (bright[i] > pwm_cnt);
         end
      end
   end

   assign bus.led_out = lit ^ {NUM_CH{(COMMON_ANODE != 0)}};

endmodule

// File: tb/tb_led_trail_chaser.sv
// Randomized scoreboard bench for led_trail_chaser: a cycle-level behavioural model predicts
// led_out for common-cathode and common-anode instances plus head position and bounce direction.
`timescale 1ns/1ps

module tb_led_trail_chaser;

   localparam int N = 4;

   typedef struct {
      bit [N-1:0] led_cc;
      bit [N-1:0] led_ca;
      int         pos;
      bit         bup;
   } exp_t;

   logic clk;
   logic reset;

   led_trail_chaser_if #(.NUM_CH(N)) bus0 ();
   led_trail_chaser_if #(.NUM_CH(N)) bus1 ();

   led_trail_chaser #(
      .NUM_CH(N), .STEP_W(6), .FADE_W(6), .BRIGHT_W(5), .COMMON_ANODE(0)
   ) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   led_trail_chaser #(
      .NUM_CH(N), .STEP_W(6), .FADE_W(6), .BRIGHT_W(5), .COMMON_ANODE(1)
   ) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   exp_t sb [$];

   // Behavioural model state, plain integers.
   int m_spd, m_dir, m_mode, m_fr;
   int m_scnt, m_fcnt, m_pcnt;
   int m_pos, m_bup;
   int m_br  [N];
   int m_lit [N];

   task automatic model_edge(input bit r, input int s, input int d, input int md, input int f);
      int nb [N];
      int nl [N];
      int period, npos, nbup;
      bit stick, ftick;
      if (r) begin
         m_spd = 0; m_dir = 0; m_mode = 0; m_fr = 0;
         m_scnt = 0; m_fcnt = 0; m_pcnt = 0;
         m_pos = 0; m_bup = 1;
         for (int i = 0; i < N; i++) begin
            m_br[i] = 0;
            m_lit[i] = 0;
         end
      end else begin
         period = (8 - m_spd) * 8;
         stick  = (m_scnt >= period - 1);
         ftick  = ((m_fcnt % (8 << m_fr)) == 0);
         for (int i = 0; i < N; i++) begin
            nl[i] = (m_br[i] > m_pcnt) ? 1 : 0;
            if (m_mode == 2 && stick)      nb[i] = 31;
            else if (m_mode != 2 && i == m_pos) nb[i] = 31;
            else if (ftick)                nb[i] = m_br[i] / 2;
            else                           nb[i] = m_br[i];
         end
         npos = m_pos;
         nbup = m_bup;
         if (stick && m_mode == 0) begin
            npos = m_dir ? (m_pos + 1) % N : (m_pos + N - 1) % N;
         end else if (stick && m_mode == 1) begin
            if (m_bup != 0) begin
               if (m_pos == N - 1) begin nbup = 0; npos = N - 2; end
               else npos = m_pos + 1;
            end else begin
               if (m_pos == 0) begin nbup = 1; npos = 1; end
               else npos = m_pos - 1;
            end
         end
         for (int i = 0; i < N; i++) begin
            m_br[i]  = nb[i];
            m_lit[i] = nl[i];
         end
         m_pos  = npos;
         m_bup  = nbup;
         m_scnt = stick ? 0 : m_scnt + 1;
         m_fcnt = (m_fcnt + 1) % 64;
         m_pcnt = (m_pcnt + 1) % 32;
         m_spd = s; m_dir = d; m_mode = md; m_fr = f;
      end
   endtask

   task automatic run_cycle(input bit r, input int s, input int d, input int md, input int f);
      exp_t e;
      reset          = r;
      bus0.speed     = 3'(s);  bus1.speed     = 3'(s);
      bus0.direction = 1'(d);  bus1.direction = 1'(d);
      bus0.mode      = 2'(md); bus1.mode      = 2'(md);
      bus0.fade_rate = 2'(f);  bus1.fade_rate = 2'(f);
      @(posedge clk);
      model_edge(r, s, d, md, f);
      for (int i = 0; i < N; i++) begin
         e.led_cc[i] = (m_lit[i] != 0);
         e.led_ca[i] = (m_lit[i] == 0);
      end
      e.pos = m_pos;
      e.bup = (m_bup != 0);
      sb.push_back(e);
      #1;
   endtask

   task automatic run_n(input int n, input bit r, input int s, input int d, input int md, input int f);
      for (int k = 0; k < n; k++) run_cycle(r, s, d, md, f);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (bus0.led_out !== e.led_cc) begin
            failures++;
            $display("FAIL led_out_cc t=%0t got=%b exp=%b", $time, bus0.led_out, e.led_cc);
         end
         checks++;
         if (bus1.led_out !== e.led_ca) begin
            failures++;
            $display("FAIL led_out_ca t=%0t got=%b exp=%b", $time, bus1.led_out, e.led_ca);
         end
         checks++;
         if (int'(u_dut0.pos) != e.pos) begin
            failures++;
            $display("FAIL pos t=%0t got=%0d exp=%0d", $time, u_dut0.pos, e.pos);
         end
         checks++;
         if (u_dut0.bounce_up !== e.bup) begin
            failures++;
            $display("FAIL bounce_up t=%0t got=%b exp=%b", $time, u_dut0.bounce_up, e.bup);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      bus0.speed = '0; bus0.direction = 1'b0; bus0.mode = '0; bus0.fade_rate = '0;
      bus1.speed = '0; bus1.direction = 1'b0; bus1.mode = '0; bus1.fade_rate = '0;
      #1;
      // chase up, chase down
      run_n(3, 1, 7, 1, 0, 0);
      run_n(60, 0, 7, 1, 0, 0);
      run_n(2, 1, 7, 0, 0, 0);
      run_n(60, 0, 7, 0, 0, 0);
      // bounce, reset while descending, resume
      run_n(2, 1, 7, 0, 1, 0);
      run_n(36, 0, 7, 0, 1, 0);
      run_n(1, 1, 7, 0, 1, 0);
      run_n(80, 0, 7, 0, 1, 0);
      // mode switch away and back keeps bounce direction and position
      run_n(20, 0, 7, 1, 3, 0);
      run_n(40, 0, 7, 1, 1, 1);
      // hold fading, slow pulse
      run_n(80, 0, 7, 0, 3, 0);
      run_n(200, 0, 0, 0, 2, 2);
      run_n(100, 0, 5, 1, 3, 3);
      // randomized segments
      for (int seg = 0; seg < 120; seg++) begin
         int s, d, md, f, len;
         if ($urandom_range(0, 19) == 0) run_n($urandom_range(1, 3), 1, $urandom_range(0, 7),
                                               $urandom_range(0, 1), $urandom_range(0, 3),
                                               $urandom_range(0, 3));
         s   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(5, 7);
         d   = $urandom_range(0, 1);
         md  = $urandom_range(0, 3);
         f   = $urandom_range(0, 3);
         len = $urandom_range(10, 150);
         run_n(len, 0, s, d, md, f);
      end
      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/led_trail_chaser.md
LED_TRAIL_CHASER -- requirements
Module: led_trail_chaser

Interface
REQ-001 Parameter NUM_CH, default 8: number of LED channels; legal range 2..32.
REQ-002 Parameter STEP_W, default 24: step-counter width; legal minimum 4.
REQ-003 Parameter FADE_W, default 21: fade-counter width; legal minimum 4.
REQ-004 Parameter BRIGHT_W, default 5: per-channel brightness and PWM counter width.
REQ-005 Parameter COMMON_ANODE, default 1: 1 inverts all outputs (active-low LEDs).
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 speed  input  3  step rate; 3'b111 is fastest.
REQ-009 direction  input  1  CHASE-mode direction; 1 = up, 0 = down.
REQ-010 mode  input  2  00 CHASE, 01 BOUNCE, 10 PULSE, 11 HOLD.
REQ-011 fade_rate  input  2  trail decay rate; 0 is fastest.
REQ-012 led_out  output  NUM_CH  registered PWM drive, one bit per channel.

Function
REQ-013 speed, direction, mode and fade_rate SHALL each be registered once before use; every effect lags the pin by 1 cycle.
REQ-014 Step counter (STEP_W bits): threshold T = {~speed_r, (STEP_W-3) ones}; if cnt >= T then cnt <= 0 and step_tick = 1 for that cycle, else cnt <= cnt+1; period T+1 cycles.
REQ-015 Position pos (0..NUM_CH-1) SHALL change only on step_tick.
REQ-016 CHASE: direction_r=1 gives pos+1, wrapping NUM_CH-1 -> 0; direction_r=0 gives pos-1, wrapping 0 -> NUM_CH-1.
REQ-017 BOUNCE: an internal bounce_up flag sets the step direction; at pos NUM_CH-1 with bounce_up=1 -> bounce_up<=0, pos<=NUM_CH-2; at pos 0 with bounce_up=0 -> bounce_up<=1, pos<=1; no endpoint repeats.
REQ-018 bounce_up SHALL hold its value outside BOUNCE and resume from it on re-entry; pos SHALL NOT be altered by a mode change.
REQ-019 PULSE: pos frozen; on step_tick all channels load full brightness (all ones).
REQ-020 HOLD: pos frozen; fading continues; the head stays lit.
REQ-021 Fade counter (FADE_W bits) SHALL free-run, wrapping; fade_tick = 1 when its low K bits are all zero, where K = FADE_W-3+fade_rate_r.
REQ-022 On fade_tick every channel brightness SHALL be shifted right by 1, saturating at 0.
REQ-023 In CHASE, BOUNCE and HOLD, channel pos SHALL load all ones every cycle.
REQ-024 Priority within a cycle: head load / PULSE load > fade shift > hold.
REQ-025 PWM counter (BRIGHT_W bits) SHALL free-run, wrapping.
REQ-026 lit[i] <= (bright[i] > pwm_cnt) SHALL be registered: brightness 0 never lights, and all ones is dark 1 of 2^BRIGHT_W cycles.
REQ-027 led_out SHALL equal lit XOR {NUM_CH{COMMON_ANODE}}.
REQ-028 Latency: pos change -> head brightness full next cycle -> lit at most one further cycle.

Reset
REQ-029 While reset is high, all counters, pos, brightness and lit SHALL be cleared to 0, and bounce_up set to 1.
REQ-030 While reset is high, led_out SHALL be all ones if COMMON_ANODE = 1, else all zeros.
REQ-031 Reset SHALL override any step_tick or fade_tick in the same cycle; input registers also clear to 0.
REQ-032 Reset asserted mid-operation SHALL give the same state as power-on reset on the next edge.

Verification
Bench parameters: NUM_CH=4, STEP_W=6, FADE_W=6, BRIGHT_W=5, COMMON_ANODE=0 unless stated.
REQ-033 CHASE, speed=111, direction=1, release reset -> pos 0,1,2,3,0 with each step 8 cycles apart; with direction=0 -> 0,3,2,1,0.
REQ-034 BOUNCE, speed=111 -> pos 0,1,2,3,2,1,0,1.
REQ-035 fade_rate=0 (K=3), head leaves channel 1 -> bright[1] 31,15,7,3,1,0 at successive 8-cycle fade_ticks, then stays 0.
REQ-036 Force bright=15 in HOLD on a non-head channel before a fade_tick -> led_out bit high exactly 15 of 32 consecutive cycles; head channel high 31 of 32.
REQ-037 COMMON_ANODE=1, reset high -> led_out = 4'b1111; PULSE, speed=000 -> all channels reload to 31 every 64 cycles.
REQ-038 Reset pulsed mid-BOUNCE while descending -> next edge pos=0, bounce_up=1, led_out=0; next step goes to pos 1.
